// File: rtl/decoder_rr_arbiter_if.sv
// Request/grant bundle shared between the requesters and the round-robin
// decoder arbiter. The requester side drives enable and request lines.
interface decoder_rr_arbiter_if;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    modport master (
        output en,
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  preempt
    );

    modport slave (
        input  en,
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output preempt
    );
endinterface

// File: rtl/decoder_rr_arbiter.sv
// Eight-way round-robin arbiter driving a one-hot 3-to-8 select bank, with
// an optional cap on how long one winner may hold the bank.
module decoder_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    decoder_rr_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_e;

    state_e           state_q;
    logic [2:0]       last_q;
    logic [2:0]       idx_q;
    logic [7:0]       gnt_q;
    logic             valid_q;
    logic             preempt_q;
    logic [CNT_W-1:0] hold_q;

    logic       found_d;
    logic [2:0] winner_d;
    logic [2:0] cand_d;
    logic       expired_d;
    logic       exit_d;

    // Search starts one past the previous winner and wraps, so the last
    // winner is considered only after every other requester.
    always_comb begin
        found_d  = 1'b0;
        winner_d = last_q;
        cand_d   = last_q;
        for (int k = 1; k <= 8; k++) begin
            cand_d = last_q + k[2:0];
            if (!found_d && bus.req[cand_d]) begin
                found_d  = 1'b1;
                winner_d = cand_d;
            end
        end
    end

    always_comb begin
        expired_d = (MAX_HOLD != 0) && (hold_q == CNT_W'(MAX_HOLD));
        exit_d    = !bus.req[idx_q] || !bus.en || expired_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= 3'd7;
            idx_q     <= 3'd0;
            gnt_q     <= 8'h00;
            valid_q   <= 1'b0;
            preempt_q <= 1'b0;
            hold_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    preempt_q <= 1'b0;
                    if (bus.en && found_d) begin
                        state_q <= GRANT;
                        idx_q   <= winner_d;
                        gnt_q   <= 8'h01 << winner_d;
                        valid_q <= 1'b1;
                        hold_q  <= CNT_W'(1);
                    end
                end
                GRANT: begin
                    if (exit_d) begin
                        state_q   <= GAP;
                        gnt_q     <= 8'h00;
                        valid_q   <= 1'b0;
                        last_q    <= idx_q;
                        // A dropped request or low enable counts as release, never preemption.
                        preempt_q <= bus.req[idx_q] && bus.en;
                    end else if (hold_q != '1) begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                GAP: begin
                    state_q   <= IDLE;
                    preempt_q <= 1'b0;
                end
                default: begin
                    state_q   <= IDLE;
                    gnt_q     <= 8'h00;
                    valid_q   <= 1'b0;
                    preempt_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = valid_q;
    assign bus.preempt   = preempt_q;

endmodule
